// File: rtl/fa2_seq_adder_ctrl.sv
// -----------------------------------------------------------------------------
// fa2_seq_adder_ctrl
//
// Multi-cycle sequencer that adds two WIDTH-bit operands by pushing one 2-bit
// full-adder slice per clock through a single slice, chaining the carry through
// a carry register. One operation is in flight at a time, using a
// start/busy/done handshake.
//
// Parameters:
//   WIDTH  operand width in bits (even, >= 2); the slice count is WIDTH/2.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only in IDLE or DONE
//   sub    in   (FA2_SEQ_SUB_EN only) 1 = compute a - b, latched with operands
//   a      in   operand A, captured when start is accepted
//   b      in   operand B, captured when start is accepted
//   busy   out  high while slices are being processed
//   done   out  one-cycle pulse; sum is valid from this cycle
//   sum    out  WIDTH+1 result, MSB = final carry-out
//
// Optional feature macro: FA2_SEQ_SUB_EN
//   Defined: adds the sub port. When sub=1, B is inverted slice by slice and
//   the initial carry is 1, giving a - b in two's complement. sum[WIDTH]=1
//   means no borrow.
//   Undefined: add only, and the initial carry is always 0.
// -----------------------------------------------------------------------------
module fa2_seq_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef FA2_SEQ_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int N     = WIDTH / 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   part_q, part_d;
  logic [WIDTH:0]     sum_q, sum_d;
`ifdef FA2_SEQ_SUB_EN
  logic               sub_q, sub_d;
`endif

  logic               accept;
  logic               last_slice;
  logic [1:0]         a_slice;
  logic [1:0]         b_slice;
  logic [2:0]         slice_sum;
  logic [WIDTH-1:0]   part_ins;

  // A request is taken whenever no operation is running, so the DONE cycle can
  // launch the next operation back-to-back.
  assign accept     = start && (state_q != ST_RUN);
  assign last_slice = (cnt_q == CNT_W'(N - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can
  // infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_slice) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  assign sum = sum_q;

  // ---------------------------------------------------------------------------
  // Datapath: one 2-bit slice per RUN cycle, LSB first
  // ---------------------------------------------------------------------------
  // The operand registers shift right by two bits every slice, so the current
  // slice always sits in bits [1:0].
  assign a_slice = a_q[1:0];
`ifdef FA2_SEQ_SUB_EN
  assign b_slice = b_q[1:0] ^ {2{sub_q}};
`else
  assign b_slice = b_q[1:0];
`endif
  assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {2'b00, carry_q};

  // The partial sum with the current slice's two bits dropped into place.
  always_comb begin
    part_ins = part_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CNT_W'(i)) part_ins[2*i +: 2] = slice_sum[1:0];
    end
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    sum_d   = sum_q;
`ifdef FA2_SEQ_SUB_EN
    sub_d   = sub_q;
`endif
    if (accept) begin
      a_d     = a;
      b_d     = b;
      cnt_d   = '0;
      part_d  = '0;
`ifdef FA2_SEQ_SUB_EN
      sub_d   = sub;
      carry_d = sub;
`else
      carry_d = 1'b0;
`endif
    end else if (state_q == ST_RUN) begin
      a_d     = a_q >> 2;
      b_d     = b_q >> 2;
      carry_d = slice_sum[2];
      part_d  = part_ins;
      if (last_slice) begin
        cnt_d = '0;
        // sum is written only here, so it holds until the next completion.
        sum_d = {slice_sum[2], part_ins};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: there is no memory array here, so every register, datapath included,
  // is cleared by reset and no operation survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      part_q  <= '0;
      sum_q   <= '0;
`ifdef FA2_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
`ifdef FA2_SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

endmodule

// File: doc/fa2_seq_adder_ctrl.md
Name: fa2_seq_adder_ctrl

Overview:
- Multi-cycle sequencer that adds two WIDTH-bit operands by driving one 2-bit full-adder slice per cycle.
- Carry is chained through a carry register between slices.
- Issues one operation at a time with a start/busy/done handshake.
- Sits between a host (bench or control FSM) and the 2-bit adder datapath, so wide sums reuse a single slice.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2; number of slices N = WIDTH/2.

Ports:
- clk    input   1        rising-edge clock
- rst_n  input   1        asynchronous active-low reset
- start  input   1        request; sampled only in IDLE or DONE
- a      input   WIDTH    operand A; captured on accepted start
- b      input   WIDTH    operand B; captured on accepted start
- busy   output  1        high while slices are being processed (RUN)
- done   output  1        one-cycle pulse; sum valid from this cycle
- sum    output  WIDTH+1  result; MSB = final carry-out

Behaviour:
- Reset (rst_n=0, asynchronous, at any time including mid-RUN):
  - state=IDLE; busy=0, done=0, sum=0.
  - Internal operand shift registers, carry register, slice counter and partial-sum register all cleared.
  - No pending operation survives reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: latch a, b; carry=0; counter=0; go RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - Each edge computes slice i (bits 2i+1:2i): {c_out, s[1:0]} = a_slice + b_slice + carry.
  - s goes into partial-sum bits 2i+1:2i; carry <= c_out; counter++.
  - Edges E1..EN process slices 0..N-1, LSB first.
  - At EN: sum <= {c_out, partial with last slice}; done=1; go DONE.
  - start is ignored in RUN; a and b may change freely without effect.
- DONE (busy=0, done=1 for exactly this cycle):
  - Next edge: start=1 is accepted as a new E0 (back-to-back), giving busy=1 immediately; start=0 returns to IDLE.
- Latency:
  - busy high N cycles after E0.
  - done visible after EN, i.e. N cycles after start accepted.
  - Throughput: one op per N+1 cycles back-to-back.
- sum holds its value until the next completed operation; it is not cleared on start.
- Arithmetic: unsigned; sum width WIDTH+1, so no overflow is possible.
- WIDTH=2 degenerate case: single RUN cycle, done one cycle after start.

Optional Feature:
- Macro FA2_SEQ_SUB_EN.
- Defined: adds input port sub (1 bit), latched with operands on accepted start.
  - sub=1: B is inverted slice-wise and the initial carry is 1, so sum = a - b in two's complement.
  - sum[WIDTH]=1 means no borrow (a >= b); 0 means borrow.
  - sub=0: identical to add.
- Not defined: no sub port; initial carry is always 0; add only.

Test Plan:
1. WIDTH=8, a=8'h0D, b=8'h13, start one cycle -> busy high 4 cycles, then done pulse 1 cycle, sum=9'h020, busy=0.
2. a=8'hFF, b=8'hFF -> sum=9'h1FE after 4 RUN cycles; confirms carry chaining through all slices.
3. Start a=8'h01, b=8'h01; in the 2nd RUN cycle drive start=1 with a=8'hAA, b=8'h55 -> ignored; sum=9'h002, exactly one done pulse.
4. Start a=8'h3C, b=8'h0F; drop rst_n in the 3rd RUN cycle -> busy, done, sum go 0 immediately. Release reset and start a=8'h10, b=8'h20 -> sum=9'h030 with normal latency.
5. Hold start=1 across the done cycle with a=8'h80, b=8'h80, then a=8'h01, b=8'h02 -> first sum=9'h100, next cycle busy=1, second sum=9'h003 exactly 5 cycles after the first done.
6. With FA2_SEQ_SUB_EN: sub=1, a=8'h05, b=8'h07 -> sum=9'h0FE (borrow). sub=1, a=8'h07, b=8'h05 -> sum=9'h102.
